// File: rtl/imem_uart_loader_pkg.sv
// imem_uart_loader_pkg: loader/receiver state encodings and baud-divider helper.
// The S_CSUM state exists only when CHECKSUM_EN is defined.
package imem_uart_loader_pkg;
  typedef enum logic [2:0] {
    S_LEN_LO,
    S_LEN_HI,
    S_DATA,
`ifdef CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERR
  } state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
  // {core_rst_n, busy, done, err}
  function automatic logic [3:0] state_flags(input state_t s);
    return {s == S_DONE, !(s == S_DONE || s == S_ERR), s == S_DONE, s == S_ERR};
  endfunction
endpackage

// File: rtl/imem_uart_loader_uart_rx.sv
// uart_rx: 8N1 receiver with 2-flop synchroniser, mid-bit sampling and framing-error flag.
module uart_rx
  import imem_uart_loader_pkg::*;
#(
  parameter int CPB = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rx,
  output logic       o_valid,
  output logic [7:0] o_data,
  output logic       o_ferr
);
  localparam int CW = $clog2(CPB + 1);
  rx_state_t   r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]  r_bit;
  logic [2:0]  r_sync;  // [1] is the synchronised line, [2] its previous value
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_sync  <= 3'b111;
      r_state <= R_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      o_data  <= '0;
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[1:0], i_rx};
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
      case (r_state)
        R_IDLE: if (r_sync[2] && !r_sync[1]) begin
          r_state <= R_START;
          r_cnt   <= '0;
        end
        R_START: if (r_cnt == CW'(CPB / 2 - 1)) begin
          r_state <= r_sync[1] ? R_IDLE : R_DATA;
          r_cnt   <= '0;
          r_bit   <= '0;
        end else r_cnt <= r_cnt + 1'b1;
        R_DATA: if (r_cnt == CW'(CPB - 1)) begin
          r_cnt   <= '0;
          o_data  <= {r_sync[1], o_data[7:1]};
          r_bit   <= r_bit + 1'b1;
          r_state <= (r_bit == 3'd7) ? R_STOP : R_DATA;
        end else r_cnt <= r_cnt + 1'b1;
        R_STOP: if (r_cnt == CW'(CPB - 1)) begin
          o_valid <= r_sync[1];
          o_ferr  <= !r_sync[1];
          r_state <= R_IDLE;
          r_cnt   <= '0;
        end else r_cnt <= r_cnt + 1'b1;
        default: r_state <= R_IDLE;
      endcase
    end
endmodule

// File: rtl/imem_uart_loader.sv
// imem_uart_loader: UART boot loader packing LE words into instruction memory, core held in reset until done.
// Define CHECKSUM_EN to require a trailing XOR-of-data-bytes checksum byte after the image.
module imem_uart_loader
  import imem_uart_loader_pkg::*;
#(
  parameter int CLK_FREQ    = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DEPTH_WORDS = 1024,
  parameter int ADDR_W      = 10
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_uart_rx,
  input  logic              i_load_req,
  output logic              o_imem_we,
  output logic [ADDR_W-1:0] o_imem_addr,
  output logic [31:0]       o_imem_wdata,
  output logic              o_core_rst_n,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);
  localparam int CLKS_PER_BIT = clks_per_bit(CLK_FREQ, BAUD);
`ifdef CHECKSUM_EN
  localparam state_t S_LAST = S_CSUM;
  logic [7:0] r_csum;
`else
  localparam state_t S_LAST = S_DONE;
`endif
  logic        w_rx_valid, w_rx_ferr;
  logic [7:0]  w_rx_data;
  logic [15:0] w_len;
  state_t      r_state;
  logic [3:0]  r_flags;
  logic [15:0] r_len, r_word_cnt;
  logic [1:0]  r_byte_cnt;
  logic [23:0] r_word;
  uart_rx #(.CPB(CLKS_PER_BIT)) u_rx (
    .i_clk  (i_clk),
    .i_rst_n(i_rst_n),
    .i_rx   (i_uart_rx),
    .o_valid(w_rx_valid),
    .o_data (w_rx_data),
    .o_ferr (w_rx_ferr)
  );
  assign w_len = {w_rx_data, r_len[7:0]};
  assign {o_core_rst_n, o_busy, o_done, o_err} = r_flags;
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state      <= S_LEN_LO;
      r_flags      <= state_flags(S_LEN_LO);
      r_len        <= '0;
      r_word_cnt   <= '0;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      o_imem_we    <= 1'b0;
      o_imem_addr  <= '0;
      o_imem_wdata <= '0;
`ifdef CHECKSUM_EN
      r_csum       <= '0;
`endif
    end else begin
      o_imem_we <= 1'b0;
      if (w_rx_ferr && r_flags[2]) begin
        r_state <= S_ERR;
        r_flags <= state_flags(S_ERR);
      end else if (i_load_req && (r_state == S_DONE || r_state == S_ERR)) begin
        r_state    <= S_LEN_LO;
        r_flags    <= state_flags(S_LEN_LO);
        r_word_cnt <= '0;
        r_byte_cnt <= '0;
`ifdef CHECKSUM_EN
        r_csum     <= '0;
`endif
      end else if (w_rx_valid)
        case (r_state)
          S_LEN_LO: begin
            r_len[7:0] <= w_rx_data;
            r_state    <= S_LEN_HI;
            r_flags    <= state_flags(S_LEN_HI);
          end
          S_LEN_HI: begin
            r_len[15:8] <= w_rx_data;
            r_state <= (w_len == 16'd0) ? S_LAST : (w_len > 16'(DEPTH_WORDS)) ? S_ERR : S_DATA;
            r_flags <= state_flags((w_len == 16'd0) ? S_LAST : (w_len > 16'(DEPTH_WORDS)) ? S_ERR : S_DATA);
          end
          S_DATA: begin
            r_byte_cnt <= r_byte_cnt + 1'b1;
`ifdef CHECKSUM_EN
            r_csum     <= r_csum ^ w_rx_data;
`endif
            if (r_byte_cnt == 2'd3) begin
              o_imem_we    <= 1'b1;
              o_imem_addr  <= r_word_cnt[ADDR_W-1:0];
              o_imem_wdata <= {w_rx_data, r_word};
              r_word_cnt   <= r_word_cnt + 16'd1;
              if (r_word_cnt + 16'd1 == r_len) begin
                r_state <= S_LAST;
                r_flags <= state_flags(S_LAST);
              end
            end else r_word[r_byte_cnt*8 +: 8] <= w_rx_data;
          end
`ifdef CHECKSUM_EN
          S_CSUM: begin
            r_state <= (w_rx_data == r_csum) ? S_DONE : S_ERR;
            r_flags <= state_flags((w_rx_data == r_csum) ? S_DONE : S_ERR);
          end
`endif
          default: ;
        endcase
    end
endmodule

// File: tb/tb_imem_uart_loader.sv
// tb_imem_uart_loader: scoreboard bench; a frame-level model predicts writes and final status.
module tb_imem_uart_loader;
  localparam int CPB = 16;
  localparam logic [3:0] F_BUSY = 4'b0100, F_DONE = 4'b1010, F_ERR = 4'b0001;
  typedef logic [7:0] bq_t[$];
  typedef struct packed {logic [9:0] a; logic [31:0] d;} wr_t;
  logic clk = 0, rst_n = 0, rx = 1, load_req = 0;
  logic we, core_rst_n, busy, done, err;
  logic [9:0] addr;
  logic [31:0] wdata;
  wr_t exp_q[$];
  wr_t mon_e;
  int total = 0, bad = 0, n_we = 0, n_exp = 0;
  always #5 clk = ~clk;
  imem_uart_loader #(.CLK_FREQ(1_000_000), .BAUD(62_500), .DEPTH_WORDS(1024), .ADDR_W(10)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_uart_rx(rx), .i_load_req(load_req),
    .o_imem_we(we), .o_imem_addr(addr), .o_imem_wdata(wdata),
    .o_core_rst_n(core_rst_n), .o_busy(busy), .o_done(done), .o_err(err)
  );
  always @(negedge clk)
    if (we) begin
      n_we++;
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write addr=%h data=%h", addr, wdata);
      end else begin
        mon_e = exp_q.pop_front();
        if ({addr, wdata} !== mon_e) begin
          bad++;
          $display("FAIL write got addr=%h data=%h exp addr=%h data=%h", addr, wdata, mon_e.a, mon_e.d);
        end
      end
    end
  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask
  task automatic send_byte(input logic [7:0] b, input logic stop = 1'b1);
    @(posedge clk); #1;
    rx = 1'b0;
    repeat (CPB) @(posedge clk); #1;
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (CPB) @(posedge clk); #1;
    end
    rx = stop;
    repeat (CPB) @(posedge clk); #1;
    rx = 1'b1;
    repeat (2 * CPB) @(posedge clk); #1;
  endtask
  // Frame-level reference: queues predicted writes and returns {core_rst_n,busy,done,err}.
  task automatic model(input bq_t q, output logic [3:0] f);
    int len;
    logic [7:0] x;
    len = {q[1], q[0]};
    x = 8'h00;
    if (len > 1024) f = F_ERR;
    else begin
      for (int w = 0; w < len; w++) begin
        exp_q.push_back({w[9:0], q[2+4*w+3], q[2+4*w+2], q[2+4*w+1], q[2+4*w]});
        n_exp++;
      end
      for (int i = 0; i < 4 * len; i++) x ^= q[2+i];
`ifdef CHECKSUM_EN
      f = (q[2+4*len] == x) ? F_DONE : F_ERR;
`else
      f = F_DONE;
`endif
    end
  endtask
  task automatic run_frame(input string name, input bq_t q);
    logic [3:0] f;
    model(q, f);
    foreach (q[i]) send_byte(q[i]);
    repeat (4) @(posedge clk); #1;
    check(name, {core_rst_n, busy, done, err}, f);
  endtask
  task automatic pulse_load();
    @(posedge clk); #1;
    load_req = 1'b1;
    @(posedge clk); #1;
    load_req = 1'b0;
  endtask
  function automatic bq_t with_csum(input bq_t q, input logic bad_sum);
    bq_t r = q;
`ifdef CHECKSUM_EN
    logic [7:0] x = 8'h00;
    for (int i = 2; i < q.size(); i++) x ^= q[i];
    r.push_back(x ^ {7'd0, bad_sum});
`else
    if (bad_sum) r = q;
`endif
    return r;
  endfunction
  initial begin
    bq_t img, q;
    int len;
    img = {8'h02, 8'h00, 8'h13, 8'h00, 8'h50, 8'h00, 8'h93, 8'h00, 8'h60, 8'h00};
    repeat (5) @(posedge clk); #1;
    check("reset_flags", {core_rst_n, busy, done, err}, F_BUSY);
    check("reset_bus", {we, addr, wdata}, 43'd0);
    rst_n = 1'b1;
    run_frame("t1_two_words", with_csum(img, 1'b0));
    check("t1_we_count", n_we, 2);
    pulse_load();
    check("load_rearm_done", {core_rst_n, busy, done, err}, F_BUSY);
    run_frame("t2_zero_len", with_csum({8'h00, 8'h00}, 1'b0));
    pulse_load();
    run_frame("t3_oversize", {8'h01, 8'h04});
    pulse_load();
    check("t3_rearm", {core_rst_n, busy, done, err}, F_BUSY);
    send_byte(8'h01);
    send_byte(8'h00);
    send_byte(8'hAA, 1'b0);
    repeat (4) @(posedge clk); #1;
    check("t4_ferr", {core_rst_n, busy, done, err}, F_ERR);
    pulse_load();
    exp_q.push_back({10'd0, 32'h00500013});
    n_exp++;
    for (int i = 0; i < 7; i++) send_byte(img[i]);
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    check("t5_reset_flags", {core_rst_n, busy, done, err}, F_BUSY);
    check("t5_reset_bus", {we, addr, wdata}, 43'd0);
    rst_n = 1'b1;
    run_frame("t5_reload", with_csum(img, 1'b0));
`ifdef CHECKSUM_EN
    pulse_load();
    run_frame("t6_csum_ok", {img, 8'hB0});
    pulse_load();
    run_frame("t6_csum_bad", {img, 8'hB1});
`endif
    for (int r = 0; r < 5; r++) begin
      pulse_load();
      len = (r == 4) ? 1025 + $urandom_range(0, 3000) : $urandom_range(1, 4);
      q = {};
      q.push_back(len[7:0]);
      q.push_back(len[15:8]);
      if (len <= 1024) begin
        for (int i = 0; i < 4 * len; i++) q.push_back(8'($urandom_range(0, 255)));
        q = with_csum(q, 1'($urandom_range(0, 1)));
      end
      run_frame("rand_frame", q);
    end
    repeat (10) @(posedge clk); #1;
    check("writes_total", n_we, n_exp);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
